serial_sub: RTL and testbench

//  Bit-serial WIDTH-bit subtractor d = a - b, one bit per clock, LSB first.

---
 rtl/serial_sub.sv | 104 ++++++++++
 tb/tb_serial_sub.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor d = a - b, LSB first, one bit per clock.
// Single borrow flip-flop between bits; start/busy/done handshake, all outputs registered.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bo;
  logic             r_busy;
  logic             r_done;

  logic w_ai;
  logic w_bi;
  logic w_di;
  logic w_br_nxt;
  logic w_last;

  assign w_ai     = r_a[0];
  assign w_bi     = r_b[0];
  assign w_di     = w_ai ^ w_bi ^ r_br;
  assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // busy/done are registered from the next-state decode so they align with r_state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_RUN);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_br  <= 1'b0;
      r_bo  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_d  <= {w_di, r_d[WIDTH-1:1]};
          r_a  <= r_a >> 1;
          r_b  <= r_b >> 1;
          r_br <= w_br_nxt;
          if (w_last) r_bo <= w_br_nxt;
          else        r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign d    = r_d;
  assign bo   = r_bo;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: WIDTH=8 vector table and corner sequences, WIDTH=4 exhaustive.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8, d8;
  logic [3:0] a4, b4, d4;
  logic       busy8, done8, bo8;
  logic       busy4, done4, bo4;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8)
  );

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_bo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb);
    int cyc;
    logic [8:0] e;
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(posedge clk);
    sb8.push_back({eb, ed});
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (!done8 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("op8_latency", 32'(cyc), 32'd8);
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      chk("op8_d", 32'(d8), 32'(e[7:0]));
      chk("op8_bo", 32'(bo8), 32'(e[8]));
    end
    chk("op8_busy_at_done", 32'(busy8), 32'd0);
    @(posedge clk); #1;
    chk("op8_done_width", 32'(done8), 32'd0);
  endtask

  task automatic op4(input logic [3:0] av, input logic [3:0] bv);
    int cyc;
    logic [4:0] e;
    logic [3:0] diff;
    @(negedge clk);
    start4 = 1'b1; a4 = av; b4 = bv;
    @(posedge clk);
    diff = av - bv;
    sb4.push_back({(av < bv), diff});
    #1;
    start4 = 1'b0; a4 = ~av; b4 = ~bv;
    cyc = 0;
    while (!done4 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("op4_latency", 32'(cyc), 32'd4);
    if (sb4.size() > 0) begin
      e = sb4.pop_front();
      chk("op4_d", 32'(d4), 32'(e[3:0]));
      chk("op4_bo", 32'(bo4), 32'(e[4]));
    end
    @(posedge clk); #1;
    chk("op4_done_width", 32'(done4), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_d", 32'(d8), 32'd0);
    chk("rst_bo", 32'(bo8), 32'd0);
    chk("rst_d4", 32'(d4), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      op8(vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_bo);

    // result must hold in IDLE until the next accepted start
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_d", 32'(d8), 32'h4B);
    chk("idle_busy", 32'(busy8), 32'd0);

    // start held high through RUN and DONE: second op only at the first IDLE edge
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h10;
    @(posedge clk); #1;
    a8 = 8'h33; b8 = 8'h11;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(done8), 32'(c == 8 || c == 18));
      chk("hold_busy", 32'(busy8), 32'((c >= 1 && c <= 7) || (c >= 10 && c <= 17)));
      if (c == 8) begin
        chk("hold_first_d", 32'(d8), 32'h10);
        chk("hold_first_bo", 32'(bo8), 32'd0);
      end
      if (c == 10) begin
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'hFF;
      end
      if (c == 18) begin
        chk("hold_second_d", 32'(d8), 32'h22);
        chk("hold_second_bo", 32'(bo8), 32'd0);
      end
    end

    // async reset after three bits of a run
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_done", 32'(done8), 32'd0);
    chk("arst_d", 32'(d8), 32'd0);
    chk("arst_bo", 32'(bo8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_idle", 32'(busy8), 32'd0);
    op8(8'h10, 8'h01, 8'h0F, 1'b0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        op4(4'(x), 4'(y));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
